crosshair_ctl: RTL and testbench
================================

// Module: crosshair_ctl
// PURPOSE
//  Controller for the crosshair overlay stage. Samples raw mouse position once per frame,
//  clamps it so the 16x16 plus never leaves the active area, and drives the frame-stable
//  xpos/ypos and cursor colour into the crosshair drawing stage. Sequences left-click shots
//  (ammo, flash, cooldown) and hands each shot to hit detection via valid/ready.
// PARAMETERS
//  H_ACTIVE        800     visible pixels per line
//  V_ACTIVE        600     visible lines per frame
//  HALF            8       clamp margin (cursor half-size); must be >= 8
//  AMMO_MAX        3       shots per reload, 1..15
//  FLASH_FRAMES    4       frames cursor shows FLASH_RGB after a shot, >= 1
//  COOLDOWN_FRAMES 8       frames clicks are ignored after flash, >= 1
//  IDLE_RGB 12'hFFF | FLASH_RGB 12'hF00 | COOL_RGB 12'h888 | EMPTY_RGB 12'h444
// PORTS
//  clk          in   1   pixel clock
//  rst          in   1   synchronous reset, active-high
//  mouse_xpos   in   12  raw mouse X (clk domain)
//  mouse_ypos   in   12  raw mouse Y (clk domain)
//  mouse_left   in   1   left button level (clk domain)
//  vblnk        in   1   vertical blank from timing chain
//  game_active  in   1   high while a round is running
//  reload       in   1   one-cycle pulse: refill ammo
//  shot_ready   in   1   hit detection accepts shot
//  xpos         out  12  clamped, frame-stable cursor X
//  ypos         out  12  clamped, frame-stable cursor Y
//  cursor_rgb   out  12  colour for crosshair stage
//  shot_valid   out  1   shot pending
//  shot_x       out  12  shot X, stable while shot_valid
//  shot_y       out  12  shot Y, stable while shot_valid
//  ammo         out  4   remaining shots
// BEHAVIOUR
//  - All outputs registered. Reset: xpos=H_ACTIVE/2, ypos=V_ACTIVE/2, cursor_rgb=IDLE_RGB,
//    shot_valid=0, shot_x=shot_y=0, ammo=AMMO_MAX, state=IDLE, frame counter=0.
//  - frame_tick = vblnk & ~vblnk_q (vblnk_q registered). On a tick edge xpos/ypos load
//    clamp(mouse): x<HALF->HALF, x>H_ACTIVE-1-HALF->H_ACTIVE-1-HALF, same for y; else pass.
//    xpos/ypos never change outside tick edges.
//  - click = mouse_left & ~left_q (rising edge only; held button = one click).
//  - FSM:
//    IDLE: click & game_active & ammo!=0 -> SHOT; shot_x/y<=xpos/ypos, shot_valid<=1.
//          click with ammo==0 or !game_active ignored.
//    SHOT: hold shot_valid and shot_x/y until shot_valid&shot_ready sampled; that edge:
//          shot_valid<=0, ammo<=ammo-1, counter<=0 -> FLASH.
//    FLASH: counter++ per frame_tick; after FLASH_FRAMES ticks -> COOLDOWN, counter<=0.
//    COOLDOWN: after COOLDOWN_FRAMES ticks -> IDLE.
//    Clicks outside IDLE dropped, never queued.
//  - cursor_rgb (registered): FLASH->FLASH_RGB; COOLDOWN->COOL_RGB; IDLE/SHOT->EMPTY_RGB if
//    ammo==0 else IDLE_RGB.
//  - game_active low in any state: next edge state<=IDLE, shot_valid<=0, counter<=0,
//    no ammo change (aborted shot not counted).
//  - reload: ammo<=AMMO_MAX; wins over simultaneous shot-accept decrement. State unaffected.
//  - ammo never underflows (decrement only from SHOT, entered only with ammo!=0).
//  - rst mid-operation: full return to reset values on next edge, pending shot discarded.
// TESTING
//  1 mouse=(400,300), one vblnk rise -> xpos/ypos=(400,300) after tick; unchanged mid-frame.
//  2 mouse=(2,1000) -> xpos=8, ypos=591; mouse=(4095,0) -> xpos=791, ypos=8.
//  3 click, shot_ready low 10 cycles then high -> shot_valid 1 for 11 cycles, shot_x/y
//    stable, ammo 3->2, cursor FLASH_RGB 4 frames, COOL_RGB 8 frames, then IDLE_RGB.
//  4 three accepted shots -> ammo=0, cursor EMPTY_RGB, 4th click no shot_valid; reload ->
//    ammo=3, IDLE_RGB.
//  5 click during FLASH/COOLDOWN or with held button -> no shot; reload same edge as
//    shot accept -> ammo=3.
//  6 game_active low while shot_valid -> shot_valid 0 next edge, ammo unchanged; rst
//    mid-FLASH -> all reset values.

Source files
------------

// File: rtl/crosshair_ctl.sv
// Crosshair overlay controller: per-frame cursor sampling with edge clamping,
// left-click shot sequencing (ammo, flash, cooldown) and a valid/ready shot
// hand-off to hit detection. All outputs are registered.

// Single-axis clamp: keeps a coordinate inside [lo, hi].
module crosshair_clamp #(
    parameter int          W  = 12,
    parameter logic [11:0] LO = 12'd8,
    parameter logic [11:0] HI = 12'd791
) (
    input  logic [W-1:0] raw,
    output logic [W-1:0] clamped
);
    // Saturate below LO and above HI, pass through otherwise.
    always_comb begin
        clamped = raw;
        if (raw < W'(LO))
            clamped = W'(LO);
        else if (raw > W'(HI))
            clamped = W'(HI);
    end
endmodule

module crosshair_ctl #(
    parameter int          H_ACTIVE        = 800,
    parameter int          V_ACTIVE        = 600,
    parameter int          HALF            = 8,
    parameter int          AMMO_MAX        = 3,
    parameter int          FLASH_FRAMES    = 4,
    parameter int          COOLDOWN_FRAMES = 8,
    parameter logic [11:0] IDLE_RGB        = 12'hFFF,
    parameter logic [11:0] FLASH_RGB       = 12'hF00,
    parameter logic [11:0] COOL_RGB        = 12'h888,
    parameter logic [11:0] EMPTY_RGB       = 12'h444
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [11:0] mouse_xpos,
    input  logic [11:0] mouse_ypos,
    input  logic        mouse_left,
    input  logic        vblnk,
    input  logic        game_active,
    input  logic        reload,
    input  logic        shot_ready,
    output logic [11:0] xpos,
    output logic [11:0] ypos,
    output logic [11:0] cursor_rgb,
    output logic        shot_valid,
    output logic [11:0] shot_x,
    output logic [11:0] shot_y,
    output logic [3:0]  ammo
);
    localparam logic [1:0] IDLE     = 2'd0;
    localparam logic [1:0] SHOT     = 2'd1;
    localparam logic [1:0] FLASH    = 2'd2;
    localparam logic [1:0] COOLDOWN = 2'd3;

    localparam logic [11:0] X_LO = 12'(HALF);
    localparam logic [11:0] X_HI = 12'(H_ACTIVE - 1 - HALF);
    localparam logic [11:0] Y_LO = 12'(HALF);
    localparam logic [11:0] Y_HI = 12'(V_ACTIVE - 1 - HALF);
    localparam logic [11:0] X_RST = 12'(H_ACTIVE / 2);
    localparam logic [11:0] Y_RST = 12'(V_ACTIVE / 2);
    localparam logic [3:0]  AMMO_FULL = 4'(AMMO_MAX);
    localparam logic [7:0]  FLASH_LAST = 8'(FLASH_FRAMES - 1);
    localparam logic [7:0]  COOL_LAST  = 8'(COOLDOWN_FRAMES - 1);

    logic        vblnk_q;
    logic        left_q;
    logic        frame_tick;
    logic        click;
    logic [1:0]  state;
    logic [7:0]  frame_cnt;
    logic [11:0] x_clamped;
    logic [11:0] y_clamped;

    logic [1:0]  state_n;
    logic [7:0]  frame_cnt_n;
    logic [3:0]  ammo_n;
    logic        shot_valid_n;
    logic [11:0] shot_x_n;
    logic [11:0] shot_y_n;
    logic [11:0] rgb_n;

    assign frame_tick = vblnk & ~vblnk_q;
    assign click      = mouse_left & ~left_q;

    crosshair_clamp #(.W(12), .LO(X_LO), .HI(X_HI)) u_clamp_x (
        .raw     (mouse_xpos),
        .clamped (x_clamped)
    );

    crosshair_clamp #(.W(12), .LO(Y_LO), .HI(Y_HI)) u_clamp_y (
        .raw     (mouse_ypos),
        .clamped (y_clamped)
    );

    // Edge detectors for vertical blank and the left button.
    always_ff @(posedge clk) begin
        if (rst) begin
            vblnk_q <= 1'b0;
            left_q  <= 1'b0;
        end else begin
            vblnk_q <= vblnk;
            left_q  <= mouse_left;
        end
    end

    // Cursor position only moves on the frame tick so the drawing stage sees
    // a stable value for the whole frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            xpos <= X_RST;
            ypos <= Y_RST;
        end else if (frame_tick) begin
            xpos <= x_clamped;
            ypos <= y_clamped;
        end
    end

    // Shot sequencer next-state logic. Abort (game inactive) overrides the
    // normal transitions; reload overrides any ammo change last.
    always_comb begin
        state_n      = state;
        frame_cnt_n  = frame_cnt;
        ammo_n       = ammo;
        shot_valid_n = shot_valid;
        shot_x_n     = shot_x;
        shot_y_n     = shot_y;

        case (state)
            IDLE: begin
                if (click && game_active && ammo != 4'd0) begin
                    state_n      = SHOT;
                    shot_valid_n = 1'b1;
                    shot_x_n     = xpos;
                    shot_y_n     = ypos;
                end
            end
            SHOT: begin
                if (shot_valid && shot_ready) begin
                    state_n      = FLASH;
                    shot_valid_n = 1'b0;
                    ammo_n       = ammo - 4'd1;
                    frame_cnt_n  = 8'd0;
                end
            end
            FLASH: begin
                if (frame_tick) begin
                    if (frame_cnt == FLASH_LAST) begin
                        state_n     = COOLDOWN;
                        frame_cnt_n = 8'd0;
                    end else begin
                        frame_cnt_n = frame_cnt + 8'd1;
                    end
                end
            end
            default: begin
                if (frame_tick) begin
                    if (frame_cnt == COOL_LAST) begin
                        state_n     = IDLE;
                        frame_cnt_n = 8'd0;
                    end else begin
                        frame_cnt_n = frame_cnt + 8'd1;
                    end
                end
            end
        endcase

        // An aborted shot is not charged against ammo.
        if (!game_active) begin
            state_n      = IDLE;
            shot_valid_n = 1'b0;
            frame_cnt_n  = 8'd0;
            ammo_n       = ammo;
        end

        if (reload)
            ammo_n = AMMO_FULL;
    end

    // Colour follows the state being entered so it lines up with the state
    // register on the same edge.
    always_comb begin
        rgb_n = IDLE_RGB;
        case (state_n)
            FLASH:    rgb_n = FLASH_RGB;
            COOLDOWN: rgb_n = COOL_RGB;
            default:  rgb_n = (ammo_n == 4'd0) ? EMPTY_RGB : IDLE_RGB;
        endcase
    end

    // Sequencer and shot hand-off registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            frame_cnt  <= 8'd0;
            ammo       <= AMMO_FULL;
            shot_valid <= 1'b0;
            shot_x     <= 12'd0;
            shot_y     <= 12'd0;
            cursor_rgb <= IDLE_RGB;
        end else begin
            state      <= state_n;
            frame_cnt  <= frame_cnt_n;
            ammo       <= ammo_n;
            shot_valid <= shot_valid_n;
            shot_x     <= shot_x_n;
            shot_y     <= shot_y_n;
            cursor_rgb <= rgb_n;
        end
    end
endmodule

// File: tb/tb_crosshair_ctl.sv
// Self-checking bench for crosshair_ctl: table of clamp vectors fed through a
// position scoreboard, plus hand-written shot/flash/cooldown/reload sequences.
module tb_crosshair_ctl;
    logic        clk = 1'b0;
    logic        rst;
    logic [11:0] mouse_xpos, mouse_ypos;
    logic        mouse_left, vblnk, game_active, reload, shot_ready;
    logic [11:0] xpos, ypos, cursor_rgb, shot_x, shot_y;
    logic        shot_valid;
    logic [3:0]  ammo;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [11:0] mx;
        logic [11:0] my;
        logic [11:0] ex;
        logic [11:0] ey;
    } vec_t;

    typedef struct {
        logic [11:0] x;
        logic [11:0] y;
    } pos_t;

    pos_t pos_q[$];
    pos_t shot_q[$];

    crosshair_ctl dut (
        .clk(clk), .rst(rst),
        .mouse_xpos(mouse_xpos), .mouse_ypos(mouse_ypos), .mouse_left(mouse_left),
        .vblnk(vblnk), .game_active(game_active), .reload(reload), .shot_ready(shot_ready),
        .xpos(xpos), .ypos(ypos), .cursor_rgb(cursor_rgb),
        .shot_valid(shot_valid), .shot_x(shot_x), .shot_y(shot_y), .ammo(ammo)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One vblank pulse: the rising edge is the frame tick.
    task automatic frame();
        vblnk = 1'b1;
        step();
        vblnk = 1'b0;
        step();
        step();
    endtask

    // Click and have hit detection accept on the following edge.
    task automatic click_accept();
        mouse_left = 1'b1;
        step();
        mouse_left = 1'b0;
        shot_ready = 1'b1;
        step();
        shot_ready = 1'b0;
    endtask

    task automatic run_frames(input int n);
        for (int i = 0; i < n; i++) frame();
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_xpos"}, 32'(xpos), 32'd400);
        chk({tag, "_ypos"}, 32'(ypos), 32'd300);
        chk({tag, "_rgb"}, 32'(cursor_rgb), 32'hFFF);
        chk({tag, "_valid"}, 32'(shot_valid), 32'd0);
        chk({tag, "_shot_x"}, 32'(shot_x), 32'd0);
        chk({tag, "_shot_y"}, 32'(shot_y), 32'd0);
        chk({tag, "_ammo"}, 32'(ammo), 32'd3);
    endtask

    initial begin
        vec_t vecs[8];
        pos_t p;
        int   vcnt;

        vecs[0] = '{12'd400, 12'd300, 12'd400, 12'd300};
        vecs[1] = '{12'd2, 12'd1000, 12'd8, 12'd591};
        vecs[2] = '{12'd4095, 12'd0, 12'd791, 12'd8};
        vecs[3] = '{12'd8, 12'd8, 12'd8, 12'd8};
        vecs[4] = '{12'd791, 12'd591, 12'd791, 12'd591};
        vecs[5] = '{12'd792, 12'd592, 12'd791, 12'd591};
        vecs[6] = '{12'd7, 12'd7, 12'd8, 12'd8};
        vecs[7] = '{12'd123, 12'd456, 12'd123, 12'd456};

        rst = 1'b1; mouse_xpos = 12'd0; mouse_ypos = 12'd0; mouse_left = 1'b0;
        vblnk = 1'b0; game_active = 1'b1; reload = 1'b0; shot_ready = 1'b0;
        step(); step();
        rst = 1'b0;
        check_reset("reset");

        // Position clamp table through the scoreboard, plus mid-frame stability.
        foreach (vecs[i]) begin
            mouse_xpos = vecs[i].mx;
            mouse_ypos = vecs[i].my;
            pos_q.push_back('{vecs[i].ex, vecs[i].ey});
            frame();
            if (pos_q.size() == 0) begin
                chk("pos_q_empty", 32'd1, 32'd0);
            end else begin
                p = pos_q.pop_front();
                chk($sformatf("clamp_x[%0d]", i), 32'(xpos), 32'(p.x));
                chk($sformatf("clamp_y[%0d]", i), 32'(ypos), 32'(p.y));
                mouse_xpos = 12'(i * 37 + 50);
                mouse_ypos = 12'(i * 53 + 20);
                step(); step(); step();
                chk($sformatf("midframe_x[%0d]", i), 32'(xpos), 32'(p.x));
                chk($sformatf("midframe_y[%0d]", i), 32'(ypos), 32'(p.y));
            end
        end

        // Single shot with delayed ready, then flash and cooldown.
        mouse_xpos = 12'd400; mouse_ypos = 12'd300;
        frame();
        mouse_left = 1'b1;
        shot_q.push_back('{12'd400, 12'd300});
        step();
        vcnt = 0;
        for (int i = 0; i < 10; i++) begin
            if (shot_valid) vcnt++;
            chk("hold_shot_x", 32'(shot_x), 32'(shot_q[0].x));
            chk("hold_shot_y", 32'(shot_y), 32'(shot_q[0].y));
            step();
        end
        shot_ready = 1'b1;
        if (shot_valid) begin
            vcnt++;
            p = shot_q.pop_front();
            chk("accept_x", 32'(shot_x), 32'(p.x));
            chk("accept_y", 32'(shot_y), 32'(p.y));
        end else begin
            chk("valid_at_ready", 32'(shot_valid), 32'd1);
        end
        step();
        shot_ready = 1'b0;
        mouse_left = 1'b0;
        chk("valid_cycles", 32'(vcnt), 32'd11);
        chk("valid_dropped", 32'(shot_valid), 32'd0);
        chk("ammo_after_1", 32'(ammo), 32'd2);
        chk("rgb_flash0", 32'(cursor_rgb), 32'hF00);
        for (int f = 1; f <= 12; f++) begin
            frame();
            if (f < 4)       chk($sformatf("rgb_f%0d", f), 32'(cursor_rgb), 32'hF00);
            else if (f < 12) chk($sformatf("rgb_f%0d", f), 32'(cursor_rgb), 32'h888);
            else             chk($sformatf("rgb_f%0d", f), 32'(cursor_rgb), 32'hFFF);
        end

        // Empty the magazine, attempt a fourth shot, then reload.
        click_accept();
        run_frames(12);
        chk("ammo_after_2", 32'(ammo), 32'd1);
        click_accept();
        run_frames(12);
        chk("ammo_empty", 32'(ammo), 32'd0);
        chk("rgb_empty", 32'(cursor_rgb), 32'h444);
        mouse_left = 1'b1;
        step();
        chk("no_shot_empty", 32'(shot_valid), 32'd0);
        step();
        chk("no_shot_empty2", 32'(shot_valid), 32'd0);
        mouse_left = 1'b0;
        reload = 1'b1;
        step();
        reload = 1'b0;
        chk("reload_ammo", 32'(ammo), 32'd3);
        chk("reload_rgb", 32'(cursor_rgb), 32'hFFF);

        // Clicks during flash and cooldown are dropped, never queued.
        click_accept();
        mouse_left = 1'b1; step(); mouse_left = 1'b0; step();
        chk("flash_click", 32'(shot_valid), 32'd0);
        run_frames(5);
        chk("in_cooldown", 32'(cursor_rgb), 32'h888);
        mouse_left = 1'b1; step(); mouse_left = 1'b0; step();
        chk("cool_click", 32'(shot_valid), 32'd0);
        run_frames(7);
        chk("back_idle", 32'(cursor_rgb), 32'hFFF);
        chk("not_queued", 32'(shot_valid), 32'd0);
        chk("ammo_after_drop", 32'(ammo), 32'd2);

        // Held button produces exactly one shot.
        mouse_left = 1'b1;
        step();
        shot_ready = 1'b1;
        step();
        shot_ready = 1'b0;
        run_frames(12);
        step(); step();
        chk("held_no_reshot", 32'(shot_valid), 32'd0);
        chk("held_ammo", 32'(ammo), 32'd1);
        mouse_left = 1'b0;
        step();

        // Reload on the same edge as shot accept wins.
        mouse_left = 1'b1;
        step();
        mouse_left = 1'b0;
        shot_ready = 1'b1;
        reload = 1'b1;
        step();
        shot_ready = 1'b0;
        reload = 1'b0;
        chk("reload_vs_accept", 32'(ammo), 32'd3);
        chk("reload_accept_rgb", 32'(cursor_rgb), 32'hF00);
        run_frames(12);

        // Abort while a shot is pending.
        mouse_xpos = 12'd200; mouse_ypos = 12'd100;
        frame();
        mouse_left = 1'b1;
        step();
        mouse_left = 1'b0;
        chk("abort_pre_valid", 32'(shot_valid), 32'd1);
        chk("abort_pre_x", 32'(shot_x), 32'd200);
        game_active = 1'b0;
        step();
        chk("abort_valid", 32'(shot_valid), 32'd0);
        chk("abort_ammo", 32'(ammo), 32'd3);
        chk("abort_rgb", 32'(cursor_rgb), 32'hFFF);
        game_active = 1'b1;
        step();

        // Reset in the middle of a flash.
        click_accept();
        frame();
        chk("pre_rst_rgb", 32'(cursor_rgb), 32'hF00);
        chk("pre_rst_ammo", 32'(ammo), 32'd2);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_reset("midrst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
